// File: rtl/led7_reader.sv
// led7_reader: decodes a held two-digit active-low 7-segment code pair back to 0..99
// and flags illegal codes and breaks in the +1 / wrap-to-0 count sequence.
module led7_reader #(
    parameter int STABLE = 4
) (
    input  logic       ck,
    input  logic       rs,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    output logic [6:0] value,
    output logic       valid,
    output logic       new_val,
    output logic       bad_code,
    output logic       err,
    output logic       step_err,
    output logic [7:0] err_cnt
);
    logic [15:0] seg_q, seg_d, cand_q, cand_d, last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  value_q, value_d, prev_q, prev_d;
    logic        valid_q, valid_d, err_q, err_d, have_prev_q, have_prev_d;
    logic        new_q, new_d, bad_q, bad_d, step_q, step_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [4:0]  du, dt;
    logic [6:0]  val;
    logic        accept, blank, legal, step_ok;

    // {legal, digit}; any code with dp lit falls through to illegal
    function automatic logic [4:0] dec(input logic [7:0] c);
        case (c)
            8'hC0:   dec = 5'h10;
            8'hF9:   dec = 5'h11;
            8'hA4:   dec = 5'h12;
            8'hB0:   dec = 5'h13;
            8'h99:   dec = 5'h14;
            8'h92:   dec = 5'h15;
            8'h82:   dec = 5'h16;
            8'hF8:   dec = 5'h17;
            8'h80:   dec = 5'h18;
            8'h90:   dec = 5'h19;
            default: dec = 5'h00;
        endcase
    endfunction

    assign du      = dec(cand_q[7:0]);
    assign dt      = dec(cand_q[15:8]);
    assign val     = 7'(dt[3:0]) * 7'd10 + 7'(du[3:0]);
    assign blank   = cand_q == 16'hFFFF;
    assign legal   = du[4] && dt[4];
    assign accept  = seg_q == cand_q && cnt_q == 4'(STABLE - 1) && cand_q != last_q;
    assign step_ok = val == prev_q + 7'd1 || val == 7'd0 || val == prev_q;

    always_comb begin
        seg_d       = {seg2, seg1};
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        value_d     = value_q;
        valid_d     = valid_q;
        err_d       = err_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        err_cnt_d   = err_cnt_q;
        new_d       = 1'b0;
        bad_d       = 1'b0;
        step_d      = 1'b0;
        if (seg_q != cand_q) begin
            cand_d = seg_q;
            cnt_d  = 4'd1;
        end else if (cnt_q < 4'(STABLE)) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (accept) begin
            last_d = cand_q;
            if (blank) begin
                valid_d     = 1'b0;
                have_prev_d = 1'b0;
            end else if (legal) begin
                value_d     = val;
                valid_d     = 1'b1;
                err_d       = 1'b0;
                new_d       = 1'b1;
                step_d      = have_prev_q && !step_ok;
                err_cnt_d   = (step_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
                prev_d      = val;
                have_prev_d = 1'b1;
            end else begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                bad_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            seg_q       <= 16'hFFFF;
            cand_q      <= 16'hFFFF;
            last_q      <= 16'hFFFF;
            cnt_q       <= 4'd0;
            value_q     <= 7'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            prev_q      <= 7'd0;
            have_prev_q <= 1'b0;
            err_cnt_q   <= 8'd0;
            new_q       <= 1'b0;
            bad_q       <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            cand_q      <= cand_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            err_cnt_q   <= err_cnt_d;
            new_q       <= new_d;
            bad_q       <= bad_d;
            step_q      <= step_d;
        end
    end

    assign value    = value_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign new_val  = new_q;
    assign bad_code = bad_q;
    assign step_err = step_q;
endmodule
